// File: rtl/alu_writeback_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_writeback_stage_if
// Description : Bundle of signals between the ALU execute block, the
//               writeback stage and the register-file write port.
//               master : upstream/consumer side (drives ALU results and tags,
//                        out_ready, exc_clr).
//               slave  : the writeback stage itself.
//               Ports carried:
//                 in_valid/in_ready, cls, result, result2, of, uof, equal,
//                 trap_en, wr_reg, exc_clr                 (into the stage)
//                 out_valid/out_ready, out_data, out_reg,
//                 out_wen, out_uof, hi, lo, last_equal, exc_ovf (out of it)
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_writeback_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        cls;
  logic [DATA_W-1:0] result;
  logic [DATA_W-1:0] result2;
  logic              of;
  logic              uof;
  logic              equal;
  logic              trap_en;
  logic [REG_W-1:0]  wr_reg;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [REG_W-1:0]  out_reg;
  logic              out_wen;
  logic              out_uof;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;
  logic              last_equal;
  logic              exc_ovf;
  logic              exc_clr;

  modport master (
    output in_valid, cls, result, result2, of, uof, equal, trap_en, wr_reg,
    output out_ready, exc_clr,
    input  in_ready, out_valid, out_data, out_reg, out_wen, out_uof,
    input  hi, lo, last_equal, exc_ovf
  );

  modport slave (
    input  in_valid, cls, result, result2, of, uof, equal, trap_en, wr_reg,
    input  out_ready, exc_clr,
    output in_ready, out_valid, out_data, out_reg, out_wen, out_uof,
    output hi, lo, last_equal, exc_ovf
  );
endinterface
`default_nettype wire

// File: rtl/alu_writeback_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_writeback_stage
// Description : Writeback stage behind the RISC ALU. Holds the HI/LO
//               registers, raises the sticky signed-overflow trap for
//               add/sub, and buffers GPR writes in an in-order circular
//               queue with a valid/ready handshake to the register file.
// Ports       : clock  - rising-edge clock
//               reset  - asynchronous active-high reset
//               bus    - alu_writeback_stage_if.slave (inputs from the ALU,
//                        queue head toward the register file, HI/LO,
//                        last_equal, exc_ovf / exc_clr)
// Revision    : 1.0 - initial release
// ============================================================================
module alu_writeback_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int DEPTH  = 2
) (
  input  wire logic              clock,
  input  wire logic              reset,
  alu_writeback_stage_if.slave   bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [1:0] c_cls_alu  = 2'd0;
  localparam logic [1:0] c_cls_hilo = 2'd1;
  localparam logic [1:0] c_cls_mfhi = 2'd2;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [REG_W-1:0]  rd;
    logic              wen;
    logic              uof;
  } entry_t;

  entry_t            r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;
  logic              r_last_equal;
  logic              r_exc_ovf;

  logic              w_in_ready;
  logic              w_accept;
  logic              w_push;
  logic              w_pop;
  logic              w_trap;
  logic              w_rd_nz;
  entry_t            w_entry;

  // No bypass: a full queue refuses input even if the head pops this cycle.
  assign w_in_ready = (r_count < CNT_W'(DEPTH));
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_push     = w_accept && (bus.cls != c_cls_hilo);
  assign w_pop      = (r_count != '0) && bus.out_ready;
  assign w_trap     = w_accept && (bus.cls == c_cls_alu) && bus.trap_en && bus.of;
  assign w_rd_nz    = (bus.wr_reg != '0);

  // MFHI/MFLO read HI/LO as they were before this edge.
  always_comb begin
    w_entry      = '0;
    w_entry.rd   = bus.wr_reg;
    w_entry.wen  = w_rd_nz;
    if (bus.cls == c_cls_alu) begin
      w_entry.data = bus.result;
      w_entry.wen  = w_rd_nz && !(bus.trap_en && bus.of);
      w_entry.uof  = bus.uof;
    end else if (bus.cls == c_cls_mfhi) begin
      w_entry.data = r_hi;
    end else begin
      w_entry.data = r_lo;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_hi         <= '0;
      r_lo         <= '0;
      r_last_equal <= 1'b0;
      r_exc_ovf    <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CNT_W'(1);
      end
      if (w_accept) begin
        r_last_equal <= bus.equal;
        if (bus.cls == c_cls_hilo) begin
          r_hi <= bus.result2;
          r_lo <= bus.result;
        end
      end
      // A trap in the same edge as a clear keeps the flag set.
      if (w_trap) begin
        r_exc_ovf <= 1'b1;
      end else if (bus.exc_clr) begin
        r_exc_ovf <= 1'b0;
      end
    end
  end

  // Queue storage needs no reset: out_valid gates every read of it.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_entry;
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = (r_count != '0);
  assign bus.out_data   = r_mem[r_rptr].data;
  assign bus.out_reg    = r_mem[r_rptr].rd;
  assign bus.out_wen    = r_mem[r_rptr].wen;
  assign bus.out_uof    = r_mem[r_rptr].uof;
  assign bus.hi         = r_hi;
  assign bus.lo         = r_lo;
  assign bus.last_equal = r_last_equal;
  assign bus.exc_ovf    = r_exc_ovf;

endmodule
`default_nettype wire

// File: tb/tb_alu_writeback_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_writeback_stage
// Description : Scoreboard bench for alu_writeback_stage. The driver pushes
//               expected queue entries and updates a reference model of
//               HI/LO/last_equal/exc_ovf; a monitor pops and compares on
//               every handshake at the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_writeback_stage;
  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int DEPTH  = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_writeback_stage_if #(.DATA_W(DATA_W), .REG_W(REG_W)) bus ();

  alu_writeback_stage #(.DATA_W(DATA_W), .REG_W(REG_W), .DEPTH(DEPTH)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [REG_W-1:0]  rg;
    logic              wen;
    logic              uof;
  } exp_t;

  exp_t              sb[$];
  logic [DATA_W-1:0] m_hi, m_lo;
  logic              m_eq, m_exc;
  int                n_cmp = 0;
  int                n_err = 0;
  bit                pop_pending = 0;
  bit                started = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares the queue head and architectural state at each falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      pop_pending = 0;
      if (started && !rst) begin
        chk("out_valid", bus.out_valid, sb.size() != 0);
        chk("hi", bus.hi, m_hi);
        chk("lo", bus.lo, m_lo);
        chk("last_equal", bus.last_equal, m_eq);
        chk("exc_ovf", bus.exc_ovf, m_exc);
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
          if (sb.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL unexpected_pop: got data %0h expected nothing", bus.out_data);
          end else begin
            e = sb.pop_front();
            chk("head", {bus.out_data, bus.out_reg, bus.out_wen, bus.out_uof},
                        {e.data, e.rg, e.wen, e.uof});
            pop_pending = 1;
          end
        end
      end
    end
  end

  // Presents one instruction (called at posedge+1) and holds it until accepted.
  task automatic issue(input logic [1:0] c, input logic [31:0] r, input logic [31:0] r2,
                       input logic of_, input logic uof_, input logic eq, input logic te,
                       input logic [4:0] wr, input logic clr, input bit rnd_rdy);
    bit   acc = 0;
    exp_t e;
    bus.in_valid = 1'b1; bus.cls = c; bus.result = r; bus.result2 = r2;
    bus.of = of_; bus.uof = uof_; bus.equal = eq; bus.trap_en = te;
    bus.wr_reg = wr; bus.exc_clr = clr;
    if (rnd_rdy) bus.out_ready = 1'($urandom_range(0, 1));
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk); #1;
      chk("in_ready", bus.in_ready, (sb.size() + int'(pop_pending)) < DEPTH);
      acc = (bus.in_ready === 1'b1);
      if (acc && c != 2'd1) begin
        e.data = (c == 2'd0) ? r : (c == 2'd2) ? m_hi : m_lo;
        e.rg   = wr;
        e.wen  = (c == 2'd0) ? (!(te && of_) && wr != 0) : (wr != 0);
        e.uof  = (c == 2'd0) ? uof_ : 1'b0;
        sb.push_back(e);
      end
      @(posedge clk);
      if (acc) begin
        m_eq = eq;
        if (c == 2'd1) begin m_hi = r2; m_lo = r; end
      end
      if (acc && c == 2'd0 && te && of_) m_exc = 1'b1;
      else if (clr) m_exc = 1'b0;
      #1;
      clr = 1'b0; bus.exc_clr = 1'b0;
      if (rnd_rdy) bus.out_ready = 1'($urandom_range(0, 1));
    end
    if (!acc) begin
      n_cmp++; n_err++;
      $display("FAIL accept_timeout: got in_ready=0 for 50 cycles expected accept");
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n, input bit rnd_rdy);
    for (int k = 0; k < n; k++) begin
      if (rnd_rdy) bus.out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
  endtask

  task automatic model_reset();
    sb.delete();
    m_hi = '0; m_lo = '0; m_eq = 1'b0; m_exc = 1'b0;
    pop_pending = 0;
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 0; bus.cls = 0; bus.result = 0; bus.result2 = 0; bus.of = 0;
    bus.uof = 0; bus.equal = 0; bus.trap_en = 0; bus.wr_reg = 0;
    bus.out_ready = 0; bus.exc_clr = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_hilo", {bus.hi, bus.lo}, 0);
    chk("rst_flags", {bus.exc_ovf, bus.last_equal}, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    started = 1;

    // DIV 677/12 then MFHI r8, MFLO r9
    bus.out_ready = 1'b1;
    issue(2'd1, 32'd56, 32'd5, 0, 0, 1, 0, 5'd0, 0, 0);
    issue(2'd2, 32'hDEAD, 32'hBEEF, 0, 0, 0, 0, 5'd8, 0, 0);
    issue(2'd3, 32'h1234, 32'h5678, 0, 0, 1, 0, 5'd9, 0, 0);
    idle(3, 0);
    chk("div_hi", bus.hi, 32'd5);
    chk("div_lo", bus.lo, 32'd56);

    // MUL 24*453: HI/LO only, queue stays empty
    issue(2'd1, 32'd10872, 32'd0, 0, 0, 0, 0, 5'd7, 0, 0);
    idle(2, 0);
    chk("mul_lo", bus.lo, 32'd10872);
    chk("mul_no_push", bus.out_valid, 0);

    // Overflow trap, non-trapping variant, clear colliding with a new trap, plain clear
    issue(2'd0, 32'hB03C9FB1, 32'd0, 1, 0, 0, 1, 5'd3, 0, 0);
    idle(2, 0);
    chk("trap_set", bus.exc_ovf, 1);
    issue(2'd0, 32'hB03C9FB1, 32'd0, 1, 1, 0, 0, 5'd3, 0, 0);
    issue(2'd0, 32'hB03C9FB1, 32'd0, 1, 0, 0, 1, 5'd3, 1, 0);
    idle(1, 0);
    chk("trap_beats_clr", bus.exc_ovf, 1);
    issue(2'd0, 32'd1, 32'd0, 0, 0, 0, 0, 5'd4, 1, 0);
    idle(1, 0);
    chk("clr", bus.exc_ovf, 0);

    // wr_reg = 0 suppresses the write without trapping
    issue(2'd0, 32'd123, 32'd0, 0, 0, 0, 1, 5'd0, 0, 0);
    idle(3, 0);

    // Backpressure: two entries fill the queue, the third waits
    bus.out_ready = 1'b0;
    issue(2'd0, 32'd10, 32'd0, 0, 0, 0, 0, 5'd1, 0, 0);
    issue(2'd0, 32'd20, 32'd0, 0, 0, 0, 0, 5'd2, 0, 0);
    bus.in_valid = 1'b1; bus.cls = 2'd0; bus.result = 32'd30; bus.wr_reg = 5'd5;
    @(negedge clk); #1;
    chk("full_in_ready", bus.in_ready, 0);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    issue(2'd0, 32'd30, 32'd0, 0, 0, 0, 0, 5'd5, 0, 0);
    idle(4, 0);

    // Asynchronous reset with two entries queued
    bus.out_ready = 1'b0;
    issue(2'd1, 32'h1111, 32'h2222, 0, 0, 1, 0, 5'd0, 0, 0);
    issue(2'd0, 32'hA, 32'd0, 1, 0, 1, 1, 5'd6, 0, 0);
    issue(2'd0, 32'hB, 32'd0, 0, 0, 1, 0, 5'd7, 0, 0);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", bus.out_valid, 0);
    chk("async_rst_ready", bus.in_ready, 1);
    chk("async_rst_hilo", {bus.hi, bus.lo}, 0);
    chk("async_rst_exc", bus.exc_ovf, 0);
    model_reset();
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [4:0] wr;
      wr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      issue(2'($urandom_range(0, 3)), $urandom, $urandom,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), wr, ($urandom_range(0, 7) == 0), 1);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)), 1);
    end

    // Drain
    bus.out_ready = 1'b1;
    for (int k = 0; k < 20 && sb.size() != 0; k++) begin
      @(posedge clk); #1;
    end
    idle(2, 0);
    chk("drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
